// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: shared state encoding and default widths for pipeline register stages
package pipe_stage_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;
  localparam int DEF_DATA_W = 138;
  localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// sat_counter: saturating up-counter with clear, clear beats increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  localparam logic [W-1:0] ONE_C = W'(1);
  // count up on each increment request, stick at all-ones
  always_ff @(posedge i_clk)
    o_cnt <= (i_rst || i_clr) ? '0 : (i_inc && !(&o_cnt)) ? o_cnt + ONE_C : o_cnt;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer pipeline register with flush and stall counter
module pipe_skid_stage
  import pipe_stage_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DATA,
  input  logic              OUT_READY,
  input  logic              FLUSH,
  input  logic              CNT_CLR,
  output logic [CNT_W-1:0]  STALL_CNT
);
  stage_state_e      r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, r_skid, w_main_d;
  logic              r_in_ready;
  logic              w_acc_in, w_acc_out, w_ld_main, w_ld_skid, w_sel_skid, w_stall;

  assign IN_READY   = r_in_ready & ~RESET;
  assign OUT_VALID  = r_state != EMPTY;
  assign OUT_DATA   = r_main;
  assign w_acc_in   = IN_VALID & IN_READY;
  assign w_acc_out  = OUT_VALID & OUT_READY;
  assign w_main_d   = w_sel_skid ? r_skid : IN_DATA;
  assign w_stall    = OUT_VALID & ~OUT_READY;

  // next occupancy and which register loads; flush empties without touching data
  always_comb begin
    w_state_nxt = r_state;
    w_ld_main   = 1'b0;
    w_ld_skid   = 1'b0;
    w_sel_skid  = 1'b0;
    if (FLUSH) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_acc_in) begin
          w_state_nxt = ONE;
          w_ld_main   = 1'b1;
        end
        ONE: if (w_acc_in && w_acc_out) begin
          w_ld_main = 1'b1;
        end else if (w_acc_in) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = TWO;
        end else if (w_acc_out) begin
          w_state_nxt = EMPTY;
        end
        TWO: if (w_acc_out) begin
          w_ld_main   = 1'b1;
          w_sel_skid  = 1'b1;
          w_state_nxt = ONE;
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // occupancy, registered ready and the main entry
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= RESET_VAL;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_state_nxt != TWO;
      if (w_ld_main) r_main <= w_main_d;
    end
  end

  // skid entry needs no reset: its validity is carried by the state
  always_ff @(posedge CLK)
    if (w_ld_skid) r_skid <= IN_DATA;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk(CLK),
    .i_rst(RESET),
    .i_inc(w_stall),
    .i_clr(CNT_CLR),
    .o_cnt(STALL_CNT)
  );
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: queue-model checking of the skid stage with directed and random traffic
module tb_pipe_skid_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [3:0] stall_cnt;

  int n_chk = 0, n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] m_data;
  logic [3:0] m_cnt;
  bit         m_rdy, live = 0, seen55 = 0;

  pipe_skid_stage #(.DATA_W(8), .RESET_VAL(8'hFF), .CNT_W(4)) dut (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready),
    .OUT_VALID(out_valid), .OUT_DATA(out_data), .OUT_READY(out_ready),
    .FLUSH(flush), .CNT_CLR(cnt_clr), .STALL_CNT(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // reference: the stage is a FIFO of depth two with a sticky last-output value
  always @(posedge clk) begin
    bit acc_in, acc_out;
    live = 1;
    if (rst) begin
      q.delete();
      m_data = 8'hFF;
      m_cnt  = 0;
      m_rdy  = 1;
    end else begin
      if (cnt_clr) m_cnt = 0;
      else if (q.size() > 0 && !out_ready && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
      if (flush) begin
        q.delete();
      end else begin
        acc_in  = in_valid && m_rdy;
        acc_out = q.size() > 0 && out_ready;
        if (acc_out) void'(q.pop_front());
        if (acc_in) q.push_back(in_data);
        if (q.size() > 0) m_data = q[0];
      end
      m_rdy = q.size() < 2;
    end
  end

  // compare every cycle against the model
  always @(negedge clk) if (live) begin
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_data", out_data, m_data);
    chk("in_ready", in_ready, m_rdy && !rst);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (out_valid && out_data == 8'h55) seen55 = 1;
  end

  initial begin
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'hFF);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    step();
    chk("post_rst_ready", in_ready, 1);
    out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1;
      in_data  = 8'(i);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
    end
    in_valid = 0;
    step();
    chk("stream_drain", out_valid, 0);
    out_ready = 0;
    in_valid  = 1;
    in_data   = 8'h21;
    step();
    in_data = 8'h22;
    step();
    chk("bp_ready_low", in_ready, 0);
    in_data = 8'h23;
    step();
    chk("bp_hold_main", out_data, 8'h21);
    chk("bp_still_full", in_ready, 0);
    out_ready = 1;
    step();
    chk("bp_out2", out_data, 8'h22);
    step();
    chk("bp_out3", out_data, 8'h23);
    in_valid = 0;
    step();
    chk("bp_empty", out_valid, 0);
    out_ready = 0;
    in_valid  = 1;
    in_data   = 8'h31;
    step();
    in_data = 8'h32;
    step();
    flush   = 1;
    in_data = 8'h55;
    step();
    flush    = 0;
    in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_data_kept", out_data, 8'h31);
    in_valid = 1;
    in_data  = 8'h41;
    step();
    flush   = 1;
    in_data = 8'h55;
    step();
    flush    = 0;
    in_valid = 0;
    chk("flush_one_valid", out_valid, 0);
    out_ready = 1;
    repeat (3) step();
    chk("never_55", seen55, 0);
    cnt_clr   = 1;
    out_ready = 0;
    step();
    cnt_clr  = 0;
    in_valid = 1;
    in_data  = 8'h61;
    step();
    in_valid = 0;
    repeat (20) step();
    chk("cnt_sat", stall_cnt, 15);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("cnt_clr_wins", stall_cnt, 0);
    step();
    chk("cnt_one", stall_cnt, 1);
    flush = 1;
    step();
    flush = 0;
    chk("cnt_flush_keeps", stall_cnt, 2);
    in_valid = 1;
    in_data  = 8'h71;
    step();
    in_data = 8'h72;
    step();
    rst = 1;
    step();
    rst      = 0;
    in_valid = 0;
    chk("mid_rst_data", out_data, 8'hFF);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", stall_cnt, 0);
    for (int i = 0; i < 3000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = 8'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      flush     = $urandom_range(0, 31) == 0;
      cnt_clr   = $urandom_range(0, 63) == 0;
      rst       = $urandom_range(0, 199) == 0;
      if (i >= 1000 && i < 1300) out_ready = 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 138, payload width (EX/MEM bundle: rd, PC, ALU result, data2, immediate, control bits).
REQ-002 The block SHALL have parameter RESET_VAL, default all-zero, value loaded into OUT_DATA on reset.
REQ-003 The block SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-005 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-006 IN_VALID  input  1  upstream stage presents a valid payload.
REQ-007 IN_DATA  input  DATA_W  upstream payload.
REQ-008 IN_READY  output  1  stage can accept a payload this cycle.
REQ-009 OUT_VALID  output  1  OUT_DATA holds a valid payload.
REQ-010 OUT_DATA  output  DATA_W  downstream payload.
REQ-011 OUT_READY  input  1  downstream accepts; memory busywait is presented here as OUT_READY=0.
REQ-012 FLUSH  input  1  discard all held and incoming payloads.
REQ-013 CNT_CLR  input  1  clear the stall counter.
REQ-014 STALL_CNT  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-015 The block SHALL define accept_in = IN_VALID & IN_READY and accept_out = OUT_VALID & OUT_READY.
REQ-016 The block SHALL hold two entries, main (drives OUT_DATA/OUT_VALID) and skid, tracked by the states EMPTY, ONE and TWO.
REQ-017 In EMPTY, accept_in SHALL load main and go to ONE; otherwise the block SHALL stay in EMPTY.
REQ-018 In ONE, accept_in with accept_out SHALL load main and stay in ONE.
REQ-019 In ONE, accept_in without accept_out SHALL load skid and go to TWO.
REQ-020 In ONE, accept_out without accept_in SHALL go to EMPTY.
REQ-021 In ONE, with neither accept_in nor accept_out, the block SHALL hold.
REQ-022 In TWO, accept_out SHALL move skid to main and go to ONE; otherwise the block SHALL hold.
REQ-023 IN_READY SHALL be a registered output, 1 in EMPTY and ONE and 0 in TWO; it SHALL be forced to 0 combinationally while RESET=1.
REQ-024 Latency SHALL be one cycle from accept_in to OUT_VALID; throughput SHALL be one payload per cycle with OUT_READY held high; no payload SHALL be dropped or duplicated.
REQ-025 OUT_DATA SHALL stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 FLUSH=1 SHALL put the block in EMPTY on the next edge: OUT_VALID=0, same-cycle IN_VALID discarded, OUT_DATA left unchanged.
REQ-027 Precedence SHALL be RESET, then FLUSH, then normal operation.
REQ-028 STALL_CNT SHALL increment by 1 on each edge with OUT_VALID=1 and OUT_READY=0, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-029 CNT_CLR SHALL zero STALL_CNT and SHALL win over a same-cycle increment.
REQ-030 FLUSH SHALL NOT alter STALL_CNT.

Reset
REQ-031 On a posedge CLK with RESET=1, state SHALL be EMPTY, OUT_VALID=0, OUT_DATA=RESET_VAL, skid entry invalid and STALL_CNT=0.
REQ-032 IN_READY SHALL be 1 on the first cycle after RESET deasserts.
REQ-033 RESET asserted mid-transfer SHALL discard both entries with no partial update.

Structure
REQ-034 State encodings (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and default DATA_W/CNT_W SHALL live in the shared package pipe_stage_pkg for reuse by the IF/ID, ID/EX and MEM/WB instances.
REQ-035 The stall counter SHALL be a sub-module sat_counter, parametrised by width, with inc/clr/reset inputs.
REQ-036 The datapath SHALL be two DATA_W registers plus one 2:1 mux, with no other storage.

Verification (DATA_W=8, CNT_W=4, RESET_VAL=8'hFF)
REQ-037 Reset: RESET=1 for 2 cycles -> OUT_VALID=0, OUT_DATA=8'hFF, STALL_CNT=0, IN_READY=0; one cycle after release -> IN_READY=1.
REQ-038 Streaming: 0x01..0x10 on consecutive cycles with OUT_READY=1 -> the same 16 values in order, one cycle later, no gaps.
REQ-039 Back-pressure: OUT_READY=0 while sending 0x21, 0x22, 0x23 -> 0x21 in main, 0x22 in skid, IN_READY=0 so 0x23 is held; OUT_READY=1 -> 0x21, 0x22, 0x23 delivered in order.
REQ-040 Flush: in TWO with FLUSH=1 and IN_VALID=1 (0x55) -> next cycle OUT_VALID=0, IN_READY=1, 0x55 never appears.
REQ-041 Counter: OUT_VALID=1, OUT_READY=0 for 20 cycles -> STALL_CNT=15 (saturated); CNT_CLR with a stall in the same cycle -> STALL_CNT=0.
